// File: rtl/ps2_key_tracker_pkg.sv
// Shared PS/2 keycode header: make codes, protocol bytes, parser states and stack commands.
// Included by ps2_key_tracker and its key stack.
package ps2_key_tracker_pkg;

    // Protocol bytes
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_OVR0   = 8'h00;
    localparam logic [7:0] PS2_OVR1   = 8'hFF;

    // Set-2 make codes used by the piano keyboard mapping
    localparam logic [7:0] KEY_Z = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_X = 8'h22;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_C = 8'h21;
    localparam logic [7:0] KEY_V = 8'h2A;
    localparam logic [7:0] KEY_G = 8'h34;
    localparam logic [7:0] KEY_B = 8'h32;
    localparam logic [7:0] KEY_H = 8'h33;
    localparam logic [7:0] KEY_N = 8'h31;
    localparam logic [7:0] KEY_J = 8'h3B;
    localparam logic [7:0] KEY_M = 8'h3A;
    localparam logic [7:0] KEY_A = 8'h1C;

    // Parser state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_MAKE  = 2'd1,
        OP_BREAK = 2'd2,
        OP_CLEAR = 2'd3
    } stk_op_e;

    // Keyboard status/response bytes that never carry a key
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ECHO);
    endfunction

endpackage

// File: rtl/ps2_key_tracker_key_stack.sv
// Last-pressed-wins held-key stack. Slot 0 is the top (newest); valid entries are
// always contiguous from slot 0, and codes are unique within the stack.
module ps2_key_tracker_key_stack
    import ps2_key_tracker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  stk_op_e       op,
    input  logic [7:0]    code,
    output logic          hit,
    output logic [7:0]    top,
    output logic [CW-1:0] count,
    output logic          evict
);

    logic [DEPTH-1:0][7:0] ent, ent_nx, ent_up, ent_dn;
    logic [DEPTH-1:0]      vld, vld_nx, vld_up, vld_dn;
    logic [DEPTH-1:0]      match, thru, take_up, take_dn;
    logic [CW-1:0]         count_nx;
    logic                  evict_nx;

    // thru[i]: the matching entry sits at slot i or newer
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            match[i] = vld[i] && (ent[i] == code);
        thru[0] = match[0];
        for (int i = 1; i < DEPTH; i++)
            thru[i] = thru[i-1] | match[i];
    end

    assign hit = thru[DEPTH-1];

    // Whole-stack one-slot shifts toward older (up) and toward the top (dn)
    assign ent_up = {ent[DEPTH-2:0], code};
    assign vld_up = {vld[DEPTH-2:0], 1'b1};
    assign ent_dn = ent >> 8;
    assign vld_dn = vld >> 1;

    // Move-to-top only shifts the slots newer than the hit; a fresh push shifts all
    assign take_up = hit ? ~(thru << 1) : '1;
    assign take_dn = hit ? thru : '0;

    always_comb begin
        ent_nx   = ent;
        vld_nx   = vld;
        count_nx = count;
        evict_nx = 1'b0;
        case (op)
            OP_MAKE: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (take_up[i]) begin
                        ent_nx[i] = ent_up[i];
                        vld_nx[i] = vld_up[i];
                    end
                end
                if (!hit) begin
                    evict_nx = vld[DEPTH-1];
                    if (!vld[DEPTH-1])
                        count_nx = count + CW'(1);
                end
            end
            OP_BREAK: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (take_dn[i]) begin
                        ent_nx[i] = ent_dn[i];
                        vld_nx[i] = vld_dn[i];
                    end
                end
                if (hit)
                    count_nx = count - CW'(1);
            end
            OP_CLEAR: begin
                ent_nx   = '0;
                vld_nx   = '0;
                count_nx = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent   <= '0;
            vld   <= '0;
            count <= '0;
            evict <= 1'b0;
        end else begin
            ent   <= ent_nx;
            vld   <= vld_nx;
            count <= count_nx;
            evict <= evict_nx;
        end
    end

    assign top = vld[0] ? ent[0] : 8'h00;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scancode parser feeding a held-key stack; presents the newest held key.
// Optional PS2_REPEAT_FILTER_EN: typematic repeat makes are swallowed entirely.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    input  logic                         flush,
    output logic [7:0]                   keycode,
    output logic                         key_held,
    output logic [$clog2(DEPTH+1)-1:0]   held_count,
    output logic                         key_event,
    output logic                         overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state, state_nx;
    logic [TW-1:0] tmo;
    logic [7:0]    last_top;
    logic          restrike, restrike_q;
    logic          hit;
    stk_op_e       op;

    ps2_key_tracker_key_stack #(.DEPTH(DEPTH), .CW(CW)) u_stack (
        .clk    (clk),
        .resetn (resetn),
        .op     (op),
        .code   (rx_data),
        .hit    (hit),
        .top    (keycode),
        .count  (held_count),
        .evict  (overflow)
    );

    always_comb begin
        op       = OP_NONE;
        state_nx = state;
        restrike = 1'b0;
        if (flush) begin
            op       = OP_CLEAR;
            state_nx = ST_IDLE;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == PS2_BRK)
                        state_nx = ST_BRK;
                    else if (rx_data == PS2_EXT)
                        state_nx = ST_EXT;
                    else if (rx_data == PS2_OVR0 || rx_data == PS2_OVR1)
                        op = OP_CLEAR;
                    else if (!is_ignored(rx_data)) begin
`ifdef PS2_REPEAT_FILTER_EN
                        if (!hit)
                            op = OP_MAKE;
`else
                        op       = OP_MAKE;
                        restrike = hit && (keycode == rx_data);
`endif
                    end
                end
                ST_BRK: begin
                    op       = OP_BREAK;
                    state_nx = ST_IDLE;
                end
                ST_EXT:  state_nx = (rx_data == PS2_BRK) ? ST_EXT_BRK : ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && tmo == TMO_LAST) begin
            state_nx = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            tmo        <= '0;
            last_top   <= 8'h00;
            restrike_q <= 1'b0;
        end else begin
            state      <= state_nx;
            last_top   <= keycode;
            restrike_q <= restrike;
            if (flush || rx_valid || state == ST_IDLE || tmo == TMO_LAST)
                tmo <= '0;
            else
                tmo <= tmo + TW'(1);
        end
    end

    // Event fires in the first cycle the new top is visible, or on a re-strike
    assign key_event = (keycode != last_top) | restrike_q;
    assign key_held  = (held_count != '0);

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: directed test-plan sequences plus random
// scancode traffic checked against a queue-based behavioural model.
module tb_ps2_key_tracker;
    import ps2_key_tracker_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 40;

    logic       clk = 1'b0, resetn = 1'b0, rx_valid = 1'b0, flush = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] keycode;
    logic       key_held, key_event, overflow;
    logic [2:0] held_count;

    always #5 clk = ~clk;

    ps2_key_tracker #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .flush      (flush),
        .keycode    (keycode),
        .key_held   (key_held),
        .held_count (held_count),
        .key_event  (key_event),
        .overflow   (overflow)
    );

    typedef struct {
        int kc;
        int cnt;
        int ev;
        int ovf;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] stk[$];   // model stack, stk[0] = newest held key
    int         pst;      // 0 idle, 1 after F0, 2 after E0, 3 after E0 F0
    int         idle_cnt;
    int         total = 0, bad = 0;
    logic       fired;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int mtop();
        return (stk.size() != 0) ? int'(stk[0]) : 0;
    endfunction

    task automatic push_exp(input int ev, input int ovf);
        exp_t e;
        e.kc  = mtop();
        e.cnt = stk.size();
        e.ev  = ev;
        e.ovf = ovf;
        expq.push_back(e);
    endtask

    task automatic model_make(input logic [7:0] b, output int rs, output int ovf);
        int idx[$];
        rs  = 0;
        ovf = 0;
        idx = stk.find_first_index(x) with (x == b);
        if (idx.size() != 0) begin
`ifndef PS2_REPEAT_FILTER_EN
            if (idx[0] == 0) rs = 1;
            else begin
                stk.delete(idx[0]);
                stk.push_front(b);
            end
`endif
        end else begin
            if (stk.size() == DEPTH) begin
                void'(stk.pop_back());
                ovf = 1;
            end
            stk.push_front(b);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int old, rs, ovf;
        int idx[$];
        old = mtop();
        rs  = 0;
        ovf = 0;
        if (pst != 0 && idle_cnt >= TMO) pst = 0;
        idle_cnt = 0;
        case (pst)
            0: begin
                if (b == 8'hF0) pst = 1;
                else if (b == 8'hE0) pst = 2;
                else if (b == 8'h00 || b == 8'hFF) stk.delete();
                else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE})) model_make(b, rs, ovf);
            end
            1: begin
                idx = stk.find_first_index(x) with (x == b);
                if (idx.size() != 0) stk.delete(idx[0]);
                pst = 0;
            end
            2: pst = (b == 8'hF0) ? 3 : 0;
            default: pst = 0;
        endcase
        push_exp(((mtop() != old) || rs != 0) ? 1 : 0, ovf);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        flush    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        model_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            flush    = 1'b0;
            idle_cnt++;
        end
    endtask

    task automatic do_flush(input logic with_byte, input logic [7:0] b);
        int old;
        @(negedge clk);
        flush    = 1'b1;
        rx_valid = with_byte;
        rx_data  = b;
        old      = mtop();
        stk.delete();
        pst      = 0;
        idle_cnt = 0;
        push_exp((old != 0) ? 1 : 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_keycode"}, keycode, 0);
        chk({tag, "_key_held"}, key_held, 0);
        chk({tag, "_held_count"}, held_count, 0);
        chk({tag, "_key_event"}, key_event, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    // Monitor: one expected entry per cycle that carried rx_valid or flush
    always @(posedge clk or negedge resetn) begin
        if (!resetn) fired <= 1'b0;
        else         fired <= rx_valid | flush;
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (fired) begin
                if (expq.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("keycode", keycode, e.kc);
                    chk("held_count", held_count, e.cnt);
                    chk("key_held", key_held, (e.cnt != 0) ? 1 : 0);
                    chk("key_event", key_event, e.ev);
                    chk("overflow", overflow, e.ovf);
                end
            end else begin
                chk("idle_key_event", key_event, 0);
                chk("idle_overflow", overflow, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool [6];
        logic [7:0] ign  [4];
        int r, n;
        pool = '{KEY_Z, KEY_S, KEY_X, KEY_C, KEY_V, KEY_A};
        ign  = '{8'hAA, 8'hFA, 8'hFE, 8'hEE};
        pst = 0;
        idle_cnt = 0;

        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // Z then X, release X, release Z
        send(KEY_Z); idle(2); send(KEY_X); idle(2);
        send(8'hF0); send(KEY_X); idle(2);
        send(8'hF0); send(KEY_Z); idle(3);

        // Overflow on the fifth distinct key; break of evicted key is a no-op
        send(KEY_Z); send(KEY_S); send(KEY_X); send(KEY_C); send(KEY_V); idle(1);
        send(8'hF0); send(KEY_Z); idle(2);
        do_flush(1'b0, 8'h00); idle(2);

        // Extended traffic around a held key
        send(KEY_Z); send(8'hE0); send(8'h75); idle(1);
        send(8'hE0); send(8'hF0); send(8'h75); idle(2);

        // Timeout after F0 abandons the break; a shorter gap does not
        send(8'hF0); idle(TMO); send(KEY_X); idle(2);
        send(8'hF0); idle(TMO - 3); send(KEY_X); idle(2);

        // Flush collides with a byte: flush wins
        do_flush(1'b1, KEY_X); idle(2);

        // Reset asserted mid-sequence
        send(KEY_Z); send(8'hF0);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 resetn = 1'b0;
        #1 check_zero("midreset");
        expq.delete();
        stk.delete();
        pst = 0;
        idle_cnt = 0;
        @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // Typematic repeats of the top key
        send(KEY_Z); send(KEY_Z); send(KEY_Z); idle(2);
        send(KEY_X); send(KEY_Z); idle(2);

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      send(pool[$urandom_range(0, 5)]);
            else if (r < 70) send(8'hF0);
            else if (r < 77) send(8'hE0);
            else if (r < 81) send(ign[$urandom_range(0, 3)]);
            else if (r < 84) send(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
            else if (r < 90) do_flush($urandom_range(0, 1) != 0, pool[$urandom_range(0, 5)]);
            else             send(pool[$urandom_range(0, 5)]);
            n = ($urandom_range(0, 9) == 0) ? TMO + 3 : $urandom_range(0, 3);
            if (flush) n = (n == 0) ? 1 : n;
            idle(n);
        end

        idle(3);
        chk("scoreboard_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
